// File: rtl/divisor_secuencial_param.sv
// Parametrised sequential restoring divider, TAMANYO-bit operands,
// BITS_CICLO quotient bits per CALC cycle, signed/unsigned per operation.
// Start/Done handshake; Coc, Res, Done, Busy, DivCero and Ovf are registered.
// Optional macro DIV_OVF_DETECT_EN: early-exit detection of the signed
// overflow case (most negative / -1). Without it Ovf stays 0 and the case
// runs the normal iterative path, yielding the wrapped quotient.
module divisor_secuencial_param #(
    parameter int TAMANYO    = 32,
    parameter int BITS_CICLO = 1
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               Start,
    input  logic               Signo,
    input  logic [TAMANYO-1:0] Num,
    input  logic [TAMANYO-1:0] Den,
    output logic [TAMANYO-1:0] Coc,
    output logic [TAMANYO-1:0] Res,
    output logic               Done,
    output logic               Busy,
    output logic               DivCero,
    output logic               Ovf
);

    localparam int N_CICLOS = (BITS_CICLO > 0) ? (TAMANYO / BITS_CICLO) : 1;
    localparam int CNT_W    = (N_CICLOS > 1) ? $clog2(N_CICLOS) : 1;
    localparam logic [CNT_W-1:0]   CNT_INI = CNT_W'(N_CICLOS - 1);
    localparam logic [TAMANYO-1:0] MIN_NEG = {1'b1, {(TAMANYO-1){1'b0}}};

    if ((TAMANYO < 4) || ((TAMANYO % 2) != 0) ||
        !((BITS_CICLO == 1) || (BITS_CICLO == 2) || (BITS_CICLO == 4)) ||
        ((TAMANYO % BITS_CICLO) != 0)) begin : g_param_error
        $error("divisor_secuencial_param: illegal TAMANYO/BITS_CICLO combination");
    end

    typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} estado_t;

    function automatic logic [TAMANYO-1:0] negar(input logic [TAMANYO-1:0] v);
        negar = ~v + {{(TAMANYO-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [TAMANYO-1:0] abs_cond(input logic neg, input logic [TAMANYO-1:0] v);
        abs_cond = neg ? negar(v) : v;
    endfunction

    estado_t            estado_r, estado_s;
    logic [TAMANYO:0]   acc_r, acc_paso_s;
    logic [TAMANYO-1:0] q_r, q_paso_s;
    logic [TAMANYO-1:0] m_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               sig_n_r, sig_d_r;
    logic [TAMANYO-1:0] fin_coc_r, fin_res_r;
    logic               fin_dz_r, fin_ovf_r;
    logic [TAMANYO-1:0] coc_fix_s, res_fix_s;
    logic               ovf_caso_s;
    logic               den_cero_s;

    assign den_cero_s = (Den == {TAMANYO{1'b0}});

`ifdef DIV_OVF_DETECT_EN
    assign ovf_caso_s = Signo && (Num == MIN_NEG) && (Den == {TAMANYO{1'b1}});
`else
    assign ovf_caso_s = 1'b0;
`endif

    // State register with asynchronous reset.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            estado_r <= IDLE;
        end else begin
            estado_r <= estado_s;
        end
    end

    // Next-state logic: special cases (div-zero, overflow) bypass the iteration.
    always_comb begin
        estado_s = estado_r;
        case (estado_r)
            IDLE: begin
                if (Start) begin
                    if (den_cero_s || ovf_caso_s) begin
                        estado_s = FIN;
                    end else begin
                        estado_s = CALC;
                    end
                end else begin
                    estado_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    estado_s = FIX;
                end else begin
                    estado_s = CALC;
                end
            end
            FIX:     estado_s = FIN;
            FIN:     estado_s = IDLE;
            default: estado_s = IDLE;
        endcase
    end

    // BITS_CICLO restoring shift-compare-subtract steps on {ACC,Q}.
    always_comb begin
        acc_paso_s = acc_r;
        q_paso_s   = q_r;
        for (int i = 0; i < BITS_CICLO; i++) begin
            acc_paso_s = {acc_paso_s[TAMANYO-1:0], q_paso_s[TAMANYO-1]};
            q_paso_s   = {q_paso_s[TAMANYO-2:0], 1'b0};
            if (acc_paso_s >= {1'b0, m_r}) begin
                acc_paso_s  = acc_paso_s - {1'b0, m_r};
                q_paso_s[0] = 1'b1;
            end else begin
                acc_paso_s = acc_paso_s;
            end
        end
    end

    // Sign fix-up: quotient truncates toward zero, remainder follows dividend.
    always_comb begin
        coc_fix_s = (sig_n_r ^ sig_d_r) ? negar(q_r) : q_r;
        res_fix_s = sig_n_r ? negar(acc_r[TAMANYO-1:0]) : acc_r[TAMANYO-1:0];
    end

    // Datapath: operand latch, iteration, staging of the final result.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            acc_r     <= {(TAMANYO+1){1'b0}};
            q_r       <= {TAMANYO{1'b0}};
            m_r       <= {TAMANYO{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            sig_n_r   <= 1'b0;
            sig_d_r   <= 1'b0;
            fin_coc_r <= {TAMANYO{1'b0}};
            fin_res_r <= {TAMANYO{1'b0}};
            fin_dz_r  <= 1'b0;
            fin_ovf_r <= 1'b0;
        end else begin
            case (estado_r)
                IDLE: begin
                    if (Start) begin
                        sig_n_r  <= Signo & Num[TAMANYO-1];
                        sig_d_r  <= Signo & Den[TAMANYO-1];
                        q_r      <= abs_cond(Signo & Num[TAMANYO-1], Num);
                        m_r      <= abs_cond(Signo & Den[TAMANYO-1], Den);
                        acc_r    <= {(TAMANYO+1){1'b0}};
                        cnt_r    <= CNT_INI;
                        if (den_cero_s) begin
                            fin_coc_r <= {TAMANYO{1'b1}};
                            fin_res_r <= Num;
                            fin_dz_r  <= 1'b1;
                            fin_ovf_r <= 1'b0;
                        end else if (ovf_caso_s) begin
                            fin_coc_r <= MIN_NEG;
                            fin_res_r <= {TAMANYO{1'b0}};
                            fin_dz_r  <= 1'b0;
                            fin_ovf_r <= 1'b1;
                        end else begin
                            fin_dz_r  <= 1'b0;
                            fin_ovf_r <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    acc_r <= acc_paso_s;
                    q_r   <= q_paso_s;
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                FIX: begin
                    fin_coc_r <= coc_fix_s;
                    fin_res_r <= res_fix_s;
                end
                default: begin
                    fin_coc_r <= fin_coc_r;
                end
            endcase
        end
    end

    // Registered outputs: results publish together with the Done pulse.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            Coc     <= {TAMANYO{1'b0}};
            Res     <= {TAMANYO{1'b0}};
            Done    <= 1'b0;
            Busy    <= 1'b0;
            DivCero <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            Done <= (estado_r == FIN);
            Busy <= (estado_r != IDLE);
            if (estado_r == FIN) begin
                Coc     <= fin_coc_r;
                Res     <= fin_res_r;
                DivCero <= fin_dz_r;
                Ovf     <= fin_ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_divisor_secuencial_param.sv
// Self-checking bench for divisor_secuencial_param: a 32-bit/1-bit-per-cycle
// instance and a 16-bit/4-bits-per-cycle instance, checked against an
// arithmetic reference model (integer / and % on sign-interpreted values).
module tb_divisor_secuencial_param;

    logic        clk = 1'b0;
    logic        rsta;
    logic        signo;
    logic        start_a, start_b;
    logic [31:0] num_a, den_a, coc_a, res_a;
    logic [15:0] num_b, den_b, coc_b, res_b;
    logic        done_a, busy_a, dz_a, ovf_a;
    logic        done_b, busy_b, dz_b, ovf_b;

    int checks   = 0;
    int failures = 0;
    int op_id    = 0;

    always #5 clk = ~clk;

    divisor_secuencial_param #(.TAMANYO(32), .BITS_CICLO(1)) dut_a (
        .CLK(clk), .RSTa(rsta), .Start(start_a), .Signo(signo),
        .Num(num_a), .Den(den_a), .Coc(coc_a), .Res(res_a),
        .Done(done_a), .Busy(busy_a), .DivCero(dz_a), .Ovf(ovf_a)
    );

    divisor_secuencial_param #(.TAMANYO(16), .BITS_CICLO(4)) dut_b (
        .CLK(clk), .RSTa(rsta), .Start(start_b), .Signo(signo),
        .Num(num_b), .Den(den_b), .Coc(coc_b), .Res(res_b),
        .Done(done_b), .Busy(busy_b), .DivCero(dz_b), .Ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division at width w; latency in edges after t0.
    task automatic ref_model(input int w, input int b, input logic s,
                             input logic [31:0] n, input logic [31:0] d,
                             output logic [31:0] coc, output logic [31:0] res,
                             output logic dz, output logic ov, output int lat);
        longint mask, half, nv, dv;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        nv   = longint'(n) & mask;
        dv   = longint'(d) & mask;
        if (s && nv >= half) nv = nv - (mask + 1);
        if (s && dv >= half) dv = dv - (mask + 1);
        ov = 1'b0;
        if (dv == 0) begin
            coc = 32'(mask);
            res = 32'(longint'(n) & mask);
            dz  = 1'b1;
            lat = 1;
        end else begin
            coc = 32'((nv / dv) & mask);
            res = 32'((nv % dv) & mask);
            dz  = 1'b0;
            lat = w / b + 2;
`ifdef DIV_OVF_DETECT_EN
            if (s && nv == -half && dv == -1) begin
                ov  = 1'b1;
                lat = 1;
            end
`endif
        end
    endtask

    function automatic logic [31:0] o_coc(input bit sel);
        return sel ? {16'h0000, coc_b} : coc_a;
    endfunction
    function automatic logic [31:0] o_res(input bit sel);
        return sel ? {16'h0000, res_b} : res_a;
    endfunction
    function automatic logic o_done(input bit sel);
        return sel ? done_b : done_a;
    endfunction
    function automatic logic o_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    task automatic launch(input bit sel, input logic s, input logic [31:0] n, input logic [31:0] d);
        @(posedge clk); #1;
        signo = s; num_a = n; den_a = d; num_b = n[15:0]; den_b = d[15:0];
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;            // this edge is t0
        start_a = 1'b0; start_b = 1'b0;
        num_a = $urandom; den_a = $urandom; num_b = 16'($urandom); den_b = 16'($urandom);
        signo = 1'($urandom);
    endtask

    task automatic run_op(input bit sel, input logic s, input logic [31:0] n,
                          input logic [31:0] d, input bit pulse);
        logic [31:0] e_coc, e_res, g_coc, g_res;
        logic        e_dz, e_ov, g_dz, g_ov, g_busy;
        int          lat, done_at, done_cnt;
        string       t;
        ref_model(sel ? 16 : 32, sel ? 4 : 1, s, n, d, e_coc, e_res, e_dz, e_ov, lat);
        op_id++;
        t = $sformatf("op%0d_%s", op_id, sel ? "b" : "a");
        done_at = -1; done_cnt = 0;
        g_coc = 32'hx; g_res = 32'hx; g_dz = 1'bx; g_ov = 1'bx; g_busy = 1'bx;
        launch(sel, s, n, d);
        chk({t, "_busy_t0"}, 32'(o_busy(sel)), 32'd0);
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk({t, "_busy_t1"}, 32'(o_busy(sel)), 32'd1);
            if (pulse && k < lat) begin
                if (sel) start_b = 1'($urandom); else start_a = 1'($urandom);
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            if (o_done(sel)) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k; g_coc = o_coc(sel); g_res = o_res(sel);
                    g_dz = sel ? dz_b : dz_a; g_ov = sel ? ovf_b : ovf_a; g_busy = o_busy(sel);
                end
            end
            if (done_at >= 0 && k >= done_at + 4) break;
        end
        start_a = 1'b0; start_b = 1'b0;
        chk({t, "_done_edge"}, 32'(done_at), 32'(lat));
        chk({t, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({t, "_coc"}, g_coc, e_coc);
        chk({t, "_res"}, g_res, e_res);
        chk({t, "_divcero"}, 32'(g_dz), 32'(e_dz));
        chk({t, "_ovf"}, 32'(g_ov), 32'(e_ov));
        chk({t, "_busy_done"}, 32'(g_busy), 32'd1);
        chk({t, "_busy_after"}, 32'(o_busy(sel)), 32'd0);
        chk({t, "_coc_hold"}, o_coc(sel), e_coc);
    endtask

    initial begin
        int done_seen;
        logic [31:0] n, d;
        rsta = 1'b0; signo = 1'b0; start_a = 1'b0; start_b = 1'b0;
        num_a = 32'd0; den_a = 32'd0; num_b = 16'd0; den_b = 16'd0;
        #12;
        chk("rst_coc", coc_a, 32'd0);
        chk("rst_res", res_a, 32'd0);
        chk("rst_flags", {28'd0, done_a, busy_a, dz_a, ovf_a}, 32'd0);
        chk("rst_b", {coc_b, res_b}, 32'd0);
        @(posedge clk); #1; rsta = 1'b1;

        // Directed cases
        run_op(1'b0, 1'b0, 32'd100, 32'd7, 1'b0);
        chk("tp1_coc", coc_a, 32'd14);
        chk("tp1_res", res_a, 32'd2);
        run_op(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 1'b0);
        chk("tp2_coc_s", coc_a, 32'hFFFFFFF2);
        chk("tp2_res_s", res_a, 32'hFFFFFFFE);
        run_op(1'b0, 1'b0, 32'hFFFFFF9C, 32'd7, 1'b0);
        chk("tp2_coc_u", coc_a, 32'h24924916);
        run_op(1'b0, 1'b0, 32'd5, 32'd0, 1'b0);
        chk("tp3_dz_u", {dz_a, coc_a[0], res_a[2:0]}, {1'b1, 1'b1, 3'd5});
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0);
        run_op(1'b0, 1'b1, 32'd9, 32'd2, 1'b0);
        chk("tp3_dz_clear", 32'(dz_a), 32'd0);
        run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("tp4_coc", coc_a, 32'h80000000);
        run_op(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(1'b1, 1'b1, 32'h00008000, 32'h0000FFFF, 1'b0);
        run_op(1'b1, 1'b0, 32'd1000, 32'd3, 1'b1);
        chk("tp5_coc", 32'(coc_b), 32'd333);
        chk("tp5_res", 32'(res_b), 32'd1);
        run_op(1'b0, 1'b1, 32'd123457, 32'hFFFFFFF9, 1'b1);
        run_op(1'b1, 1'b1, 32'h0000FF00, 32'd0, 1'b1);

        // Reset in the middle of a CALC
        launch(1'b0, 1'b0, 32'd77777, 32'd13);
        repeat (9) @(posedge clk);
        #2; rsta = 1'b0; #1;
        chk("rst_mid_coc", coc_a, 32'd0);
        chk("rst_mid_res", res_a, 32'd0);
        chk("rst_mid_flags", {28'd0, done_a, busy_a, dz_a, ovf_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1; rsta = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (done_a || busy_a) done_seen++;
        end
        chk("rst_mid_no_done", 32'(done_seen), 32'd0);
        run_op(1'b0, 1'b0, 32'd77777, 32'd13, 1'b0);

        // Randomised operations with boundary-value injection
        for (int i = 0; i < 24; i++) begin
            n = $urandom; d = $urandom;
            case ($urandom_range(0, 5))
                0: d = 32'd0;
                1: d = 32'd1;
                2: begin n = 32'h80000000; d = 32'hFFFFFFFF; end
                3: d = d >> $urandom_range(0, 30);
                4: begin n = 32'h00008000; d = 32'h0000FFFF; end
                default: n = n >> $urandom_range(0, 20);
            endcase
            run_op(1'(i % 2), 1'($urandom), n, d, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divisor_secuencial_param.md
Name: divisor_secuencial_param

Overview:
Parametrised sequential restoring divider. Successor to the 32-bit signed-only divider.
- Width is configurable.
- Retires BITS_CICLO quotient bits per clock.
- Signed or unsigned mode is selected per operation.
- Divide-by-zero and signed-overflow are flagged.
- Sits on the datapath as a multi-cycle functional unit with a Start/Done handshake.

Parameters:
TAMANYO, 32, operand/result width in bits; even and >= 4.
BITS_CICLO, 1, quotient bits resolved per CALC cycle; legal values 1, 2, 4; must divide TAMANYO. Elaboration error otherwise.

Ports:
CLK  input  1  clock, rising edge.
RSTa  input  1  asynchronous, active-low reset.
Start  input  1  request; sampled only in IDLE.
Signo  input  1  1 = signed two's-complement operation, 0 = unsigned; sampled with Start.
Num  input  TAMANYO  dividend; sampled with Start.
Den  input  TAMANYO  divisor; sampled with Start.
Coc  output  TAMANYO  quotient, registered.
Res  output  TAMANYO  remainder, registered.
Done  output  1  one-cycle pulse; Coc/Res/flags valid.
Busy  output  1  high in every state except IDLE.
DivCero  output  1  divisor was zero; valid with Done, held until the next Done.
Ovf  output  1  signed overflow; see Optional Feature. Valid with Done.

Behaviour:
- Reset (RSTa low, asynchronous): state IDLE; Coc, Res, Done, Busy, DivCero and Ovf all 0; internal accumulator, quotient and counter cleared. Applies at any time, including mid-CALC; the aborted operation produces no Done.
- States: IDLE, CALC, FIX, FIN.
- IDLE:
  - Start=0: stay in IDLE.
  - Start=1: latch Signo. Latch |Num| and |Den| when Signo=1 and the operand is negative; otherwise raw values. Latch both sign bits. Counter = TAMANYO/BITS_CICLO - 1. Accumulator = 0. Go to CALC.
  - Start=1 with Den==0: go directly to FIN with the div-zero result.
- CALC: each cycle performs BITS_CICLO shift-compare-subtract steps.
  - One step: {ACC,Q} shifted left by 1; if ACC >= M then ACC -= M and Q[0] = 1.
  - Accumulator is TAMANYO+1 bits so the compare never overflows.
  - Counter==0: go to FIX; otherwise decrement counter.
- FIX: apply signs.
  - Coc = negate(Q) if Signo and sign(Num) != sign(Den).
  - Res = negate(ACC) if Signo and Num negative.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Go to FIN.
- FIN: Done=1 for exactly this cycle; go to IDLE. Coc, Res, DivCero and Ovf hold their values until the next FIN.
- Latency: Start sampled at edge t0; Done high in the cycle following edge t0 + TAMANYO/BITS_CICLO + 2. Divide-by-zero: Done high in the cycle following edge t0+1.
- Div-by-zero result (both modes): Coc = all ones, Res = Num (raw), DivCero=1.
- Start while Busy=1: ignored, no queuing. Start asserted in the FIN cycle: ignored. Start asserted in the first IDLE cycle: accepted.
- Unsigned mode never asserts Ovf.
- Back-to-back: minimum issue interval is latency + 1 cycle.

Optional Feature:
Macro DIV_OVF_DETECT_EN.
- Defined: in IDLE, Signo=1 with Num = 100..0 and Den = all ones is detected. The block goes directly to FIN (Done at t0+1) with Coc = 100..0, Res = 0, Ovf=1.
- Not defined: Ovf is tied to 0. The case runs the normal iterative path and yields the wrapped result Coc = 100..0, Res = 0 at full latency.

Test Plan:
1. TAMANYO=32, BITS_CICLO=1, Signo=0, Num=100, Den=7, Start at t0 -> Done in the cycle after t0+34; Coc=14, Res=2, DivCero=0, Busy high from t0+1 through the Done cycle.
2. Signo=1, Num=0xFFFFFF9C (-100), Den=7 -> Coc=0xFFFFFFF2 (-14), Res=0xFFFFFFFE (-2). Same operands with Signo=0 -> Coc=0x24924916, Res=2.
3. Num=5, Den=0, either mode -> Done in the cycle after t0+1; Coc=0xFFFFFFFF, Res=5, DivCero=1. The next normal operation clears DivCero.
4. Num=0x80000000, Den=0xFFFFFFFF, Signo=1 -> Coc=0x80000000, Res=0. With DIV_OVF_DETECT_EN: Ovf=1, Done after t0+1. Without it: Ovf=0, Done after t0+34.
5. TAMANYO=16, BITS_CICLO=4, Num=1000, Den=3 -> Done in the cycle after t0+6; Coc=333, Res=1. Start pulses during Busy produce no extra Done.
6. RSTa pulsed low at t0+10 of an operation -> all outputs 0 immediately, no Done. A fresh Start after release completes normally.
